// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the SoC bus controller: read-mux regions,
// control-register offsets, wait FSM encoding and the pclk divide ratio.
package soc_bus_pkg;

    typedef enum logic [1:0] {
        REG_RAM = 2'd0,
        REG_IO  = 2'd1,
        REG_ROM = 2'd2,
        REG_CTL = 2'd3
    } region_e;

    localparam logic [1:0] CTL_STAT = 2'd0;
    localparam logic [1:0] CTL_MASK = 2'd1;
    localparam logic [1:0] CTL_WAIT = 2'd2;
    localparam logic [1:0] CTL_PEND = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wait_state_e;

    // Integer divide ratio between system clock and peripheral pulse rate.
    function automatic int calc_div(input int clk_freq, input int periph_freq);
        int div_v;
        if (periph_freq > 0) begin
            div_v = clk_freq / periph_freq;
        end else begin
            div_v = 2;
        end
        return div_v;
    endfunction

endpackage

// File: rtl/soc_pclk_gen.sv
// Peripheral clock-enable generator: one-clk pulse every DIV system clocks,
// asserted in the cycle where the internal counter sits at DIV-1.
module soc_pclk_gen
    import soc_bus_pkg::*;
#(
    parameter int CLK_FREQ    = 40000000,
    parameter int PERIPH_FREQ = 4000000
) (
    input  logic clk,
    input  logic reset_n,
    output logic pclk
);

    localparam int DIV = calc_div(CLK_FREQ, PERIPH_FREQ);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_r;
    logic          pclk_r;

    // Wrapping divider; the pulse is registered one step ahead so it lines up with cnt_r == DIV-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r  <= '0;
            pclk_r <= 1'b0;
        end else begin
            if (cnt_r == CW'(DIV - 1)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            pclk_r <= (cnt_r == CW'(DIV - 2));
        end
    end

    assign pclk = pclk_r;

endmodule

// File: rtl/soc_bus_ctrl.sv
// SoC bus controller for the 65xx core: address decode, 1-cycle read mux,
// I/O wait states on RDY, masked IRQ aggregation and the pclk enable.
module soc_bus_ctrl
    import soc_bus_pkg::*;
#(
    parameter int         CLK_FREQ    = 40000000,
    parameter int         PERIPH_FREQ = 4000000,
    parameter int         NSLOT       = 4,
    parameter logic [3:0] IO_PAGE     = 4'h1,
    parameter logic [1:0] WAIT_RST    = 2'd0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [15:0]          cpu_ab,
    input  logic                 cpu_we_n,
    input  logic [7:0]           cpu_do,
    output logic [7:0]           cpu_di,
    output logic                 cpu_rdy,
    output logic                 cpu_irq_n,
    output logic                 pclk,
    output logic                 ram_cs,
    output logic                 ram_we,
    input  logic [7:0]           ram_do,
    input  logic [7:0]           rom_do,
    output logic [NSLOT-1:0]     io_cs_n,
    output logic                 io_we_n,
    output logic [5:0]           io_rs,
    input  logic [8*NSLOT-1:0]   io_do,
    input  logic [NSLOT-1:0]     io_irq_n
);

    localparam logic [6:0] NSLOT_W = 7'(NSLOT);
    localparam int         MW      = (NSLOT < 8) ? NSLOT : 8;

    logic [3:0]       page_s;
    logic [5:0]       slot_s;
    logic             ram_hit_s;
    logic             io_hit_s;
    logic             io_slot_s;
    logic             ctl_hit_s;
    logic             wait_req_s;
    logic             rdy_core_s;
    logic             wr_s;
    logic [NSLOT-1:0] io_cs_n_s;
    logic [NSLOT-1:0] irq_act_s;
    logic [NSLOT-1:0] mask_ext_s;
    logic [7:0]       stat8_s;
    logic [7:0]       pend8_s;
    logic [7:0]       io_rd_s;
    logic [7:0]       rd_s;
    region_e          region_s;

    wait_state_e      state_r;
    logic [1:0]       cnt_r;
    logic [1:0]       wcfg_r;
    logic [7:0]       mask_r;
    region_e          mux_sel_r;
    logic [5:0]       slot_r;
    logic [1:0]       ctl_idx_r;
    logic             cpu_irq_n_r;

    assign page_s    = cpu_ab[15:12];
    assign slot_s    = cpu_ab[11:6];
    assign ram_hit_s = (page_s == 4'h0);
    assign io_hit_s  = (page_s == IO_PAGE);
    assign io_slot_s = io_hit_s & ({1'b0, slot_s} < NSLOT_W);
    assign ctl_hit_s = io_hit_s & ({1'b0, slot_s} == NSLOT_W);
    assign wait_req_s = io_slot_s & (wcfg_r != 2'd0);

    // Per-slot active-low selects.
    always_comb begin
        io_cs_n_s = '1;
        for (int k = 0; k < NSLOT; k++) begin
            io_cs_n_s[k] = ~(io_hit_s & (slot_s == 6'(k)));
        end
    end

    // Read-source classification of the current address.
    always_comb begin
        region_s = REG_ROM;
        if (ram_hit_s) begin
            region_s = REG_RAM;
        end else if (io_slot_s) begin
            region_s = REG_IO;
        end else if (ctl_hit_s) begin
            region_s = REG_CTL;
        end else begin
            region_s = REG_ROM;
        end
    end

    // Ready decode: the first stalled cycle comes straight from the address in IDLE.
    always_comb begin
        rdy_core_s = 1'b1;
        case (state_r)
            ST_IDLE: rdy_core_s = ~wait_req_s;
            ST_WAIT: rdy_core_s = (cnt_r <= 2'd1);
            default: rdy_core_s = 1'b1;
        endcase
    end

    // Strobes use the reset-free ready so the reset term never reaches flop data paths.
    assign wr_s    = ~cpu_we_n & rdy_core_s;
    assign cpu_rdy = rdy_core_s | ~reset_n;
    assign ram_cs  = ram_hit_s;
    assign ram_we  = ram_hit_s & wr_s;
    assign io_we_n = cpu_we_n | ~rdy_core_s;
    assign io_rs   = cpu_ab[5:0];
    assign io_cs_n = io_cs_n_s;

    // Wait-state FSM; cnt is loaded only on entry, so a wcfg write mid-stall only affects later accesses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (wait_req_s) begin
                        cnt_r   <= wcfg_r;
                        state_r <= ST_WAIT;
                    end else begin
                        cnt_r   <= 2'd0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r > 2'd1) begin
                        cnt_r   <= cnt_r - 2'd1;
                        state_r <= ST_WAIT;
                    end else begin
                        cnt_r   <= 2'd0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    cnt_r   <= 2'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Writable control registers (mask and wait count).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_r <= 8'hFF;
            wcfg_r <= WAIT_RST;
        end else if (ctl_hit_s && wr_s) begin
            case (cpu_ab[1:0])
                CTL_MASK: mask_r <= cpu_do;
                CTL_WAIT: wcfg_r <= cpu_do[1:0];
                default: begin
                    mask_r <= mask_r;
                    wcfg_r <= wcfg_r;
                end
            endcase
        end else begin
            mask_r <= mask_r;
            wcfg_r <= wcfg_r;
        end
    end

    // Status/mask views: slots beyond the 8-bit mask register are always enabled.
    always_comb begin
        irq_act_s  = ~io_irq_n;
        mask_ext_s = '1;
        stat8_s    = 8'h00;
        for (int k = 0; k < MW; k++) begin
            mask_ext_s[k] = mask_r[k];
            stat8_s[k]    = irq_act_s[k];
        end
        pend8_s = stat8_s & mask_r;
    end

    // Read-select capture and level IRQ aggregation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mux_sel_r   <= REG_RAM;
            slot_r      <= 6'd0;
            ctl_idx_r   <= 2'd0;
            cpu_irq_n_r <= 1'b1;
        end else begin
            mux_sel_r   <= region_s;
            slot_r      <= slot_s;
            ctl_idx_r   <= cpu_ab[1:0];
            cpu_irq_n_r <= ~|(irq_act_s & mask_ext_s);
        end
    end

    // AND-OR select of the addressed slot's read data.
    always_comb begin
        io_rd_s = 8'h00;
        for (int k = 0; k < NSLOT; k++) begin
            io_rd_s = io_rd_s | ({8{slot_r == 6'(k)}} & io_do[8*k +: 8]);
        end
    end

    // Read data mux on the registered select, matching the 1-cycle memories.
    always_comb begin
        rd_s = rom_do;
        case (mux_sel_r)
            REG_RAM: rd_s = ram_do;
            REG_IO:  rd_s = io_rd_s;
            REG_CTL: begin
                case (ctl_idx_r)
                    CTL_STAT: rd_s = stat8_s;
                    CTL_MASK: rd_s = mask_r;
                    CTL_WAIT: rd_s = {6'b000000, wcfg_r};
                    CTL_PEND: rd_s = pend8_s;
                    default:  rd_s = 8'h00;
                endcase
            end
            REG_ROM: rd_s = rom_do;
            default: rd_s = rom_do;
        endcase
    end

    assign cpu_di    = rd_s;
    assign cpu_irq_n = cpu_irq_n_r;

    soc_pclk_gen #(
        .CLK_FREQ    (CLK_FREQ),
        .PERIPH_FREQ (PERIPH_FREQ)
    ) u_pclk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .pclk    (pclk)
    );

endmodule
